bus_frame_tx: RTL and testbench

//  Framing transmitter for the 16-bit word bus checked by the frame-checker FSM.
//  - Buffers payload beats from an upstream valid/ready source.
//  - Emits each buffered packet as: header beat, payload beats, trailer beat.
//  - Drives data_out and output_control into the bus / checker input (data_input).

---
 rtl/bus_frame_tx_if.sv | 26 ++
 rtl/bus_frame_tx.sv | 130 +++++++++++++
 tb/tb_bus_frame_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_frame_tx_if.sv
// Bus bundle for bus_frame_tx: upstream payload handshake plus the framed
// output bus that feeds the frame checker. The slave modport is the
// transmitter; the master modport is whatever drives and consumes it.
interface bus_frame_tx_if #(
  parameter int BUS_SIZE = 16,
  parameter int WORD_NUM = 4
);
  logic [BUS_SIZE-1:0] in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [BUS_SIZE-1:0] data_out;
  logic [WORD_NUM-1:0] output_control;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, data_out, output_control, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, data_out, output_control, out_valid
  );
endinterface

// File: rtl/bus_frame_tx.sv
// Framing transmitter: collects one packet of payload beats into a local
// buffer, then emits header, the buffered beats in push order, and a trailer.
// Optional feature macro: BUS_FRAME_TX_CHECKSUM_EN. When it is defined, the
// trailer is the XOR of the packet's payload beats. When it is undefined, the
// trailer is a fixed 4'hE marker word.
module bus_frame_tx #(
  parameter int BUS_SIZE   = 16,
  parameter int WORD_SIZE  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  bus_frame_tx_if.slave bus
);
  localparam int         WORD_NUM = BUS_SIZE / WORD_SIZE;
  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] LP_LAST  = 8'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD, TRAILER} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_live;        // low only until the first edge after reset
  logic [3:0]          r_seq;
  logic [7:0]          r_count;       // beats buffered in the current packet
  logic [7:0]          r_rd_idx;      // next beat to transmit
  logic [BUS_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [BUS_SIZE-1:0] r_data_out;
  logic                r_out_valid;

  logic                w_in_ready;
  logic                w_push;
  logic                w_xfer;
  logic [7:0]          w_count_nxt;
  logic [7:0]          w_rd_nxt;
  logic [BUS_SIZE-1:0] w_trailer;
  logic [BUS_SIZE-1:0] w_data_nxt;

  assign w_push = bus.in_valid & w_in_ready;
  // out_valid is high in every transmit state, so it alone qualifies a beat.
  assign w_xfer = r_out_valid & bus.out_ready;

`ifdef BUS_FRAME_TX_CHECKSUM_EN
  logic [BUS_SIZE-1:0] r_csum;

  // Running XOR of accepted payload beats; cleared as the frame completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_push) begin
      r_csum <= r_csum ^ bus.in_data;
    end else if (r_state == TRAILER && w_xfer) begin
      r_csum <= '0;
    end
  end

  assign w_trailer = r_csum;
`else
  assign w_trailer = {4'hE, {(BUS_SIZE-4){1'b0}}};
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: a packet closes on in_last or when it fills the buffer.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      COLLECT: if (w_push && (bus.in_last || r_count == LP_LAST)) w_state_nxt = HEADER;
      HEADER:  if (w_xfer) w_state_nxt = PAYLOAD;
      PAYLOAD: if (w_xfer && r_rd_idx == r_count - 8'd1) w_state_nxt = TRAILER;
      TRAILER: if (w_xfer) w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Output logic: input handshake and the value data_out takes on the next edge.
  always_comb begin
    w_in_ready  = r_live && (r_state == COLLECT) && (r_count != 8'(FIFO_DEPTH));
    w_count_nxt = (bus.in_valid && w_in_ready) ? r_count + 8'd1 : r_count;
    w_rd_nxt    = (r_state == PAYLOAD && w_xfer) ? r_rd_idx + 8'd1 : r_rd_idx;
    w_data_nxt  = '0;
    unique case (w_state_nxt)
      HEADER:  w_data_nxt = BUS_SIZE'({4'hF, r_seq, w_count_nxt});
      PAYLOAD: w_data_nxt = r_mem[w_rd_nxt[AW-1:0]];
      TRAILER: w_data_nxt = w_trailer;
      default: w_data_nxt = '0;
    endcase
  end

  // Payload buffer write port.
  // NOTE: storage is not reset; r_count marks what is valid, so stale words are never sent.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_count[AW-1:0]] <= bus.in_data;
  end

  // Counters, sequence number and registered output beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_live      <= 1'b0;
      r_seq       <= 4'd0;
      r_count     <= 8'd0;
      r_rd_idx    <= 8'd0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_data_out  <= w_data_nxt;
      r_out_valid <= (w_state_nxt != COLLECT);
      if (r_state == TRAILER && w_xfer) begin
        r_seq    <= r_seq + 4'd1;
        r_count  <= 8'd0;
        r_rd_idx <= 8'd0;
      end else begin
        r_count  <= w_count_nxt;
        r_rd_idx <= w_rd_nxt;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.data_out       = r_data_out;
  assign bus.out_valid      = r_out_valid;
  assign bus.output_control = {WORD_NUM{r_out_valid}};
endmodule

// File: tb/tb_bus_frame_tx.sv
// Testbench for bus_frame_tx: random payloads are framed by a queue-based
// reference model (header, payload, trailer) and compared beat by beat.
module tb_bus_frame_tx;
  localparam int BUS   = 16;
  localparam int WN    = 4;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bus_frame_tx_if #(.BUS_SIZE(BUS), .WORD_NUM(WN)) bus ();

  bus_frame_tx #(.BUS_SIZE(BUS), .WORD_SIZE(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  int          m_seq = 0;
  logic [15:0] exp_q[$];

  // Expected frame for one packet, straight from the framing rules.
  function automatic void build_frame(input logic [15:0] pl[$]);
    logic [15:0] x;
    logic [3:0]  s;
    x = 16'h0;
    s = 4'(m_seq);
    exp_q.delete();
    exp_q.push_back({4'hF, s, 8'(pl.size())});
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      x = x ^ pl[i];
    end
`ifdef BUS_FRAME_TX_CHECKSUM_EN
    exp_q.push_back(x);
`else
    exp_q.push_back(16'hE000);
`endif
    m_seq = (m_seq + 1) % 16;
  endfunction

  function automatic void rand_payload(input int n, output logic [15:0] pl[$]);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(16'($urandom));
  endfunction

  // Drive one packet's payload beats into the input handshake.
  task automatic send(input logic [15:0] pl[$], input bit with_last, input bit gaps);
    int n;
    for (int i = 0; i < pl.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_last  = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      bus.in_data  = pl[i];
      bus.in_valid = 1'b1;
      bus.in_last  = with_last && (i == pl.size() - 1);
      n = 0;
      while (!bus.in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!bus.in_ready) begin
        miscompares++;
        $display("FAIL send_timeout beat %0d: in_ready=%b required 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Consume exp_q from the output bus; mode 0 always ready, 1 toggle, 2 random.
  task automatic receive(input int mode);
    int          idx;
    int          cyc;
    bit          stalled;
    logic [15:0] held;
    idx = 0; cyc = 0; stalled = 0; held = '0;
    while (idx < exp_q.size() && cyc < 300) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2) == 1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== held) begin
          miscompares++;
          $display("FAIL stall_hold beat %0d: valid=%b data=%h required valid=1 data=%h",
                   idx, bus.out_valid, bus.data_out, held);
        end
      end
      stalled = 0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          vectors++;
          if (bus.data_out !== exp_q[idx] || bus.output_control !== 4'hF) begin
            miscompares++;
            $display("FAIL beat %0d: data=%h ctrl=%h required data=%h ctrl=f",
                     idx, bus.data_out, bus.output_control, exp_q[idx]);
          end
          idx++;
        end else begin
          stalled = 1;
          held    = bus.data_out;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    vectors++;
    if (idx < exp_q.size()) begin
      miscompares++;
      $display("FAIL recv_timeout: got %0d beats required %0d", idx, exp_q.size());
    end else if (bus.out_valid !== 1'b0 || bus.output_control !== 4'h0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_end: valid=%b ctrl=%h in_ready=%b required 0,0,1",
               bus.out_valid, bus.output_control, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.data_out !== 16'h0 || bus.out_valid !== 1'b0 ||
        bus.output_control !== 4'h0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: data=%h valid=%b ctrl=%h in_ready=%b required 0,0,0,0",
               bus.data_out, bus.out_valid, bus.output_control, bus.in_ready);
    end
    reset = 1'b0;
    m_seq = 0;
    @(posedge clk); #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    logic [15:0] pl[$];
    pl.push_back(16'h1234);
    build_frame(pl);
    send(pl, 1'b1, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 16'hF001) begin
      miscompares++;
      $display("FAIL header_latency: valid=%b data=%h required 1 f001",
               bus.out_valid, bus.data_out);
    end
    receive(0);
  endtask

  task automatic test_full();
    logic [15:0] pl[$];
    rand_payload(DEPTH, pl);
    build_frame(pl);
    send(pl, 1'b0, 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.data_out !== 16'hF108) begin
      miscompares++;
      $display("FAIL full_close: in_ready=%b data=%h required 0 f108",
               bus.in_ready, bus.data_out);
    end
    receive(0);
    // Following packet carries the incremented sequence number.
    rand_payload(2, pl);
    build_frame(pl);
    send(pl, 1'b1, 1'b1);
    receive(0);
  endtask

  task automatic test_backpressure();
    logic [15:0] pl[$];
    rand_payload(3, pl);
    build_frame(pl);
    send(pl, 1'b1, 1'b0);
    receive(1);
  endtask

  task automatic test_seq_wrap();
    logic [15:0] pl[$];
    for (int p = 0; p < 17; p++) begin
      rand_payload(1, pl);
      build_frame(pl);
      send(pl, 1'b1, 1'b0);
      receive(0);
    end
  endtask

  task automatic test_reset_midpacket();
    logic [15:0] pl[$];
    rand_payload(3, pl);
    build_frame(pl);
    send(pl, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== 16'h0 ||
        bus.output_control !== 4'h0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b data=%h ctrl=%h in_ready=%b required 0,0,0,0",
               bus.out_valid, bus.data_out, bus.output_control, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_seq = 0;
    @(posedge clk); #1;
    rand_payload(2, pl);
    build_frame(pl);
    send(pl, 1'b1, 1'b0);
    receive(0);
  endtask

  task automatic test_random();
    logic [15:0] pl[$];
    for (int p = 0; p < 12; p++) begin
      rand_payload($urandom_range(1, DEPTH), pl);
      build_frame(pl);
      send(pl, 1'b1, 1'b1);
      receive(2);
    end
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_backpressure();
    test_seq_wrap();
    test_reset_midpacket();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
